// File: rtl/temporal_pulse_encoder_pkg.sv
// Shared types and polarity helper for the temporal (race-logic) pulse encoder.
package temporal_enc_pkg;

    typedef enum logic {
        MODE_PULSE = 1'b0,
        MODE_STEP  = 1'b1
    } mode_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Map an internal "spike active" flag onto the physical line level.
    function automatic logic line_level(input logic active, input logic active_low);
        line_level = active ^ active_low;
    endfunction

endpackage

// File: rtl/temporal_pulse_encoder_channel.sv
// One output line: decides from the coming cycle's window position whether the
// spike for its latched value is active, and registers the resulting level.
module temporal_pulse_channel
    import temporal_enc_pkg::*;
#(
    parameter int unsigned VALUE_W    = 3,
    parameter int unsigned PULSE_LEN  = 1,
    parameter int unsigned ACTIVE_LOW = 1,
    parameter int unsigned NULL_MAX   = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [VALUE_W-1:0] value,
    input  mode_t              mode,
    input  logic [VALUE_W-1:0] t,
    input  logic               run,
    output logic               line
);

    localparam logic               LOW_IDLE   = (ACTIVE_LOW != 32'd0) ? 1'b1 : 1'b0;
    localparam logic               IDLE_LEVEL = LOW_IDLE;
    localparam logic [VALUE_W-1:0] NULL_CODE  = {VALUE_W{1'b1}};
    // Pulse end uses one extra bit so a late value with a long pulse truncates
    // at the window end instead of wrapping back to t = 0.
    localparam logic [VALUE_W:0]   PULSE_SPAN = (VALUE_W + 1)'(PULSE_LEN - 32'd1);

    logic             is_null_s;
    logic             reached_s;
    logic             in_pulse_s;
    logic             shape_s;
    logic             active_s;
    logic [VALUE_W:0] pulse_end_s;
    logic             line_r;

    // Spike shape for the cycle the register is about to present.
    always_comb begin
        is_null_s   = (NULL_MAX != 32'd0) && (value == NULL_CODE);
        reached_s   = (t >= value);
        pulse_end_s = {1'b0, value} + PULSE_SPAN;
        in_pulse_s  = ({1'b0, t} <= pulse_end_s);
        shape_s     = 1'b0;
        active_s    = 1'b0;
        case (mode)
            MODE_STEP:  shape_s = reached_s;
            MODE_PULSE: shape_s = reached_s && in_pulse_s;
            default:    shape_s = 1'b0;
        endcase
        if (run && !is_null_s) begin
            active_s = shape_s;
        end else begin
            active_s = 1'b0;
        end
    end

    // Registered line level; reset forces the idle level immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            line_r <= IDLE_LEVEL;
        end else begin
            line_r <= line_level(active_s, LOW_IDLE);
        end
    end

    assign line = line_r;

endmodule

// File: rtl/temporal_pulse_encoder.sv
// Multi-channel temporal pulse encoder: handshake, window FSM/timer and value
// latches; each channel turns its value v into a spike at window cycle t = v.
module temporal_pulse_encoder
    import temporal_enc_pkg::*;
#(
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned VALUE_W    = 3,
    parameter int unsigned PULSE_LEN  = 1,
    parameter int unsigned ACTIVE_LOW = 1,
    parameter int unsigned NULL_MAX   = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*VALUE_W-1:0]  in_values,
    input  logic                         in_mode,
    output logic [CHANNELS-1:0]          out_lines,
    output logic                         window_start,
    output logic                         window_done,
    output logic                         busy
);

    localparam logic [VALUE_W-1:0] T_FIRST = {VALUE_W{1'b0}};
    localparam logic [VALUE_W-1:0] T_LAST  = {VALUE_W{1'b1}};

    state_t                        state_r;
    state_t                        state_s;
    logic [VALUE_W-1:0]            t_r;
    logic [VALUE_W-1:0]            t_s;
    logic [CHANNELS*VALUE_W-1:0]   values_r;
    logic [CHANNELS*VALUE_W-1:0]   values_s;
    mode_t                         mode_r;
    mode_t                         mode_s;
    logic                          ready_s;
    logic                          accept_s;
    logic                          run_s;
    logic                          window_start_r;
    logic                          window_done_r;
    logic                          busy_r;

    // Ready when idle or on the last window cycle, so windows can chain with no gap.
    always_comb begin
        if ((state_r == S_IDLE) || (t_r == T_LAST)) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        accept_s = in_valid && ready_s;
    end

    // Next state and window timer.
    always_comb begin
        state_s = state_r;
        t_s     = t_r;
        case (state_r)
            S_IDLE: begin
                t_s = T_FIRST;
                if (accept_s) begin
                    state_s = S_RUN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (t_r == T_LAST) begin
                    t_s = T_FIRST;
                    if (accept_s) begin
                        state_s = S_RUN;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    state_s = S_RUN;
                    t_s     = t_r + VALUE_W'(1);
                end
            end
            default: begin
                state_s = S_IDLE;
                t_s     = T_FIRST;
            end
        endcase
    end

    // Next latched vector/mode; channels see these so their registered lines
    // line up with the timer value of the same cycle.
    always_comb begin
        if (accept_s) begin
            values_s = in_values;
            mode_s   = mode_t'(in_mode);
        end else begin
            values_s = values_r;
            mode_s   = mode_r;
        end
        run_s = (state_s == S_RUN);
    end

    // FSM, timer, latches and window status registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= S_IDLE;
            t_r            <= T_FIRST;
            values_r       <= {(CHANNELS*VALUE_W){1'b0}};
            mode_r         <= MODE_PULSE;
            window_start_r <= 1'b0;
            window_done_r  <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            t_r            <= t_s;
            values_r       <= values_s;
            mode_r         <= mode_s;
            window_start_r <= run_s && (t_s == T_FIRST);
            window_done_r  <= run_s && (t_s == T_LAST);
            busy_r         <= run_s;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        temporal_pulse_channel #(
            .VALUE_W    (VALUE_W),
            .PULSE_LEN  (PULSE_LEN),
            .ACTIVE_LOW (ACTIVE_LOW),
            .NULL_MAX   (NULL_MAX)
        ) u_chan (
            .clock (clock),
            .reset (reset),
            .value (values_s[i*VALUE_W +: VALUE_W]),
            .mode  (mode_s),
            .t     (t_s),
            .run   (run_s),
            .line  (out_lines[i])
        );
    end

    assign in_ready     = ready_s;
    assign window_start = window_start_r;
    assign window_done  = window_done_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_temporal_pulse_encoder.sv
// Randomised bench: two encoder configurations share one stimulus stream and are
// checked every cycle against a model built from the list of accepted vectors.
module tb_temporal_pulse_encoder;

    localparam int CH = 8;
    localparam int VW = 3;
    localparam int W  = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [23:0]   in_values;
    logic          in_mode;

    logic          ready_a, start_a, done_a, busy_a;
    logic [CH-1:0] lines_a;
    logic          ready_b, start_b, done_b, busy_b;
    logic [CH-1:0] lines_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit       has_acc  = 1'b0;
    int       acc_cyc  = 0;
    int       acc_val [CH];
    bit       acc_mode = 1'b0;

    temporal_pulse_encoder u_dut_a (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ready_a),
        .in_values(in_values), .in_mode(in_mode), .out_lines(lines_a),
        .window_start(start_a), .window_done(done_a), .busy(busy_a)
    );

    temporal_pulse_encoder #(
        .CHANNELS(8), .VALUE_W(3), .PULSE_LEN(3), .ACTIVE_LOW(0), .NULL_MAX(0)
    ) u_dut_b (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ready_b),
        .in_values(in_values), .in_mode(in_mode), .out_lines(lines_b),
        .window_start(start_b), .window_done(done_b), .busy(busy_b)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Window position of the current cycle, or -1 when no vector has been accepted.
    function automatic int cur_t();
        if (!has_acc) return -1;
        return cyc - acc_cyc - 1;
    endfunction

    function automatic bit in_window();
        int t;
        t = cur_t();
        return (t >= 0) && (t < W);
    endfunction

    function automatic logic [CH-1:0] exp_lines(input int plen, input bit alow, input bit nmax);
        logic [CH-1:0] r;
        int t;
        int v;
        bit act;
        t = cur_t();
        for (int i = 0; i < CH; i++) begin
            act = 1'b0;
            v   = acc_val[i];
            if (in_window() && !(nmax && (v == W - 1))) begin
                if (acc_mode) act = (t >= v);
                else          act = (t >= v) && (t <= v + plen - 1);
            end
            r[i] = alow ? !act : act;
        end
        return r;
    endfunction

    function automatic bit exp_ready();
        return !in_window() || (cur_t() == W - 1);
    endfunction

    task automatic check_outputs();
        bit inw;
        inw = in_window();
        check_val("a_lines", lines_a, exp_lines(1, 1'b1, 1'b1));
        check_val("b_lines", lines_b, exp_lines(3, 1'b0, 1'b0));
        check_val("a_start", start_a, inw && (cur_t() == 0));
        check_val("b_start", start_b, inw && (cur_t() == 0));
        check_val("a_done",  done_a,  inw && (cur_t() == W - 1));
        check_val("b_done",  done_b,  inw && (cur_t() == W - 1));
        check_val("a_busy",  busy_a,  inw);
        check_val("b_busy",  busy_b,  inw);
        check_val("a_ready", ready_a, exp_ready());
        check_val("b_ready", ready_b, exp_ready());
    endtask

    // One cycle: check what the DUTs show now, then drive inputs for this cycle's edge.
    task automatic step(input bit v, input logic [23:0] vals, input bit m);
        @(negedge clock);
        cyc++;
        check_outputs();
        in_valid  = v;
        in_values = vals;
        in_mode   = m;
        if (v && exp_ready()) begin
            has_acc  = 1'b1;
            acc_cyc  = cyc;
            acc_mode = m;
            for (int i = 0; i < CH; i++) acc_val[i] = int'(vals[i*VW +: VW]);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        cyc++;
        check_outputs();
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        has_acc = 1'b0;
        check_outputs();
        @(negedge clock);
        cyc++;
        check_outputs();
        reset = 1'b0;
    endtask

    function automatic logic [23:0] rand_vals();
        logic [23:0] r;
        logic [2:0]  x;
        for (int i = 0; i < CH; i++) begin
            case ($urandom_range(0, 3))
                0:       x = 3'd0;
                1:       x = 3'd7;
                default: x = 3'($urandom_range(0, 7));
            endcase
            r[i*VW +: VW] = x;
        end
        return r;
    endfunction

    logic [23:0] ramp;
    logic [23:0] vec_a;
    logic [23:0] vec_b;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_values = 24'd0;
        in_mode   = 1'b0;
        for (int i = 0; i < CH; i++) acc_val[i] = 0;
        for (int i = 0; i < CH; i++) ramp[i*VW +: VW] = 3'(i);
        #1;
        check_outputs();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Ramp 0..7 in pulse mode, accepted at cycle 10.
        while (cyc < 9) step(1'b0, 24'd0, 1'b0);
        step(1'b1, ramp, 1'b0);
        repeat (10) step(1'b0, rand_vals(), 1'b0);

        // Step mode with value 5 on channel 0.
        vec_a = rand_vals();
        vec_a[2:0] = 3'd5;
        step(1'b1, vec_a, 1'b1);
        repeat (10) step(1'b0, 24'd0, 1'b0);

        // Continuous valid with alternating vectors: contiguous windows.
        vec_a = rand_vals();
        vec_b = rand_vals();
        for (int n = 0; n < 40; n++) step(1'b1, n[0] ? vec_b : vec_a, n[1]);
        repeat (10) step(1'b0, 24'd0, 1'b0);

        // Step mode, all zero, reset at t = 3, then a fresh accept.
        step(1'b1, 24'd0, 1'b1);
        repeat (3) step(1'b0, 24'd0, 1'b0);
        pulse_reset();
        step(1'b1, ramp, 1'b1);
        repeat (10) step(1'b0, 24'd0, 1'b0);

        // Random traffic with occasional mid-window resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 49) == 0) pulse_reset();
            else step(($urandom_range(0, 2) != 0), rand_vals(), 1'($urandom_range(0, 1)));
        end
        repeat (10) step(1'b0, 24'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
